// File: rtl/sbox_array.sv
// ---------------------------------------------------------------------------
// sbox_array
// Multi-lane pipelined AES byte substitution (S-box / inverse S-box) with a
// valid/ready handshake and a per-beat mode bit that travels with the data.
//
// Parameters:
//   LANES      number of byte lanes per beat (1..16)
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   input beat offered
//   in_ready   unit accepts the beat this cycle (combinational from out_ready)
//   in_mode    0 = forward S-box, 1 = inverse S-box, sampled with the beat
//   in_data    LANES bytes, lane i = in_data[8i+7:8i]
//   out_valid  result beat present (registered)
//   out_ready  downstream accepts the beat
//   out_data   substituted bytes, lane-aligned with in_data (registered)
//   out_x2     2*S in GF(2^8) per lane   (only with SBOX_XTIME_EN)
//   out_x3     3*S in GF(2^8) per lane   (only with SBOX_XTIME_EN)
//
// Optional feature macro: SBOX_XTIME_EN adds the out_x2/out_x3 products,
// computed ahead of the stage-2 register.
//
// Datapath split: stage 1 applies the input linear layer (inverse affine for
// inverse mode, identity for forward mode); stage 2 performs the GF(2^8)
// inversion followed by the output linear layer (forward affine for forward
// mode, identity for inverse mode).
// ---------------------------------------------------------------------------
module sbox_array #(
   parameter int LANES = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               in_mode,
   input  logic [8*LANES-1:0] in_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [8*LANES-1:0] out_data
`ifdef SBOX_XTIME_EN
   ,
   output logic [8*LANES-1:0] out_x2,
   output logic [8*LANES-1:0] out_x3
`endif
);

   localparam int W = 8 * LANES;

   // Multiply by x modulo the AES polynomial x^8 + x^4 + x^3 + x + 1.
   function automatic logic [7:0] xtime(input logic [7:0] b);
      logic [7:0] r;
      r = {b[6:0], 1'b0};
      if (b[7]) begin
         r = r ^ 8'h1B;
      end else begin
         r = r;
      end
      return r;
   endfunction

   // Shift-and-add GF(2^8) multiply.
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) begin
            p = p ^ aa;
         end else begin
            p = p;
         end
         aa = xtime(aa);
      end
      return p;
   endfunction

   // Multiplicative inverse as b^254 (maps 0 to 0, as AES requires).
   function automatic logic [7:0] gf_inv(input logic [7:0] b);
      logic [7:0] sq;
      logic [7:0] res;
      sq  = b;
      res = 8'h01;
      for (int i = 1; i < 8; i++) begin
         sq  = gf_mul(sq, sq);
         res = gf_mul(res, sq);
      end
      return res;
   endfunction

   // Forward affine: b ^ rotl1 ^ rotl2 ^ rotl3 ^ rotl4 ^ 0x63.
   function automatic logic [7:0] fwd_affine(input logic [7:0] b);
      return b
           ^ {b[6:0], b[7]}
           ^ {b[5:0], b[7:6]}
           ^ {b[4:0], b[7:5]}
           ^ {b[3:0], b[7:4]}
           ^ 8'h63;
   endfunction

   // Inverse affine: rotl1 ^ rotl3 ^ rotl6 ^ 0x05.
   function automatic logic [7:0] inv_affine(input logic [7:0] b);
      return {b[6:0], b[7]}
           ^ {b[4:0], b[7:5]}
           ^ {b[1:0], b[7:2]}
           ^ 8'h05;
   endfunction

   logic         adv1_s;
   logic         adv2_s;
   logic         v1_r;
   logic         v2_r;
   logic         mode1_r;
   logic [W-1:0] s1_data_r;
   logic [W-1:0] s1_next_s;
   logic [W-1:0] s2_next_s;
   logic [W-1:0] out_data_r;

   // Pipeline advance: a stage moves when its downstream slot is free or draining.
   always_comb begin
      adv2_s = ~v2_r | out_ready;
      adv1_s = ~v1_r | adv2_s;
   end

   assign in_ready  = adv1_s;
   assign out_valid = v2_r;
   assign out_data  = out_data_r;

   // Stage-1 combinational input linear layer per lane.
   always_comb begin
      s1_next_s = {W{1'b0}};
      for (int l = 0; l < LANES; l++) begin
         if (in_mode) begin
            s1_next_s[8*l +: 8] = inv_affine(in_data[8*l +: 8]);
         end else begin
            s1_next_s[8*l +: 8] = in_data[8*l +: 8];
         end
      end
   end

   // Stage-2 combinational field inversion plus output linear layer per lane.
   always_comb begin
      s2_next_s = {W{1'b0}};
      for (int l = 0; l < LANES; l++) begin
         if (mode1_r) begin
            s2_next_s[8*l +: 8] = gf_inv(s1_data_r[8*l +: 8]);
         end else begin
            s2_next_s[8*l +: 8] = fwd_affine(gf_inv(s1_data_r[8*l +: 8]));
         end
      end
   end

   // Stage-1 register: linear-layer result, mode and valid bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         v1_r      <= 1'b0;
         mode1_r   <= 1'b0;
         s1_data_r <= {W{1'b0}};
      end else if (adv1_s) begin
         v1_r      <= in_valid;
         mode1_r   <= in_mode;
         s1_data_r <= s1_next_s;
      end
   end

   // Stage-2 register: final bytes and valid bit; holds while stalled.
   always_ff @(posedge clk) begin
      if (rst) begin
         v2_r       <= 1'b0;
         out_data_r <= {W{1'b0}};
      end else if (adv2_s) begin
         v2_r       <= v1_r;
         out_data_r <= s2_next_s;
      end
   end

`ifdef SBOX_XTIME_EN
   logic [W-1:0] x2_next_s;
   logic [W-1:0] x3_next_s;
   logic [W-1:0] out_x2_r;
   logic [W-1:0] out_x3_r;

   assign out_x2 = out_x2_r;
   assign out_x3 = out_x3_r;

   // MixColumns helper products of the substituted byte, ahead of the register.
   always_comb begin
      x2_next_s = {W{1'b0}};
      x3_next_s = {W{1'b0}};
      for (int l = 0; l < LANES; l++) begin
         x2_next_s[8*l +: 8] = xtime(s2_next_s[8*l +: 8]);
         x3_next_s[8*l +: 8] = xtime(s2_next_s[8*l +: 8]) ^ s2_next_s[8*l +: 8];
      end
   end

   // Stage-2 product registers, advancing in lockstep with out_data.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_x2_r <= {W{1'b0}};
         out_x3_r <= {W{1'b0}};
      end else if (adv2_s) begin
         out_x2_r <= x2_next_s;
         out_x3_r <= x3_next_s;
      end
   end
`endif

endmodule

// File: tb/tb_sbox_array.sv
// ---------------------------------------------------------------------------
// tb_sbox_array
// Scoreboard bench for sbox_array. Expected results come from S-box tables
// built at start-up from log/antilog tables over generator 3 and the bitwise
// affine formula; the inverse table is the inversion of the forward table.
// Accepted beats are pushed into a queue; a negedge monitor pops and compares
// each output transfer, checks hold-stability while stalled, and checks that
// in_ready drops only when two beats are in flight and out_ready is low.
// ---------------------------------------------------------------------------
module tb_sbox_array;

   localparam int LANES = 4;
   localparam int W     = 8 * LANES;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic         in_mode;
   logic [W-1:0] in_data;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_data;
`ifdef SBOX_XTIME_EN
   logic [W-1:0] out_x2;
   logic [W-1:0] out_x3;
`endif

   int   n_tests = 0;
   int   n_fail  = 0;
   bit   rand_ready = 1'b0;

   logic [7:0] sbox_t  [256];
   logic [7:0] isbox_t [256];

   typedef struct {
      logic [W-1:0] d;
      logic [W-1:0] x2;
      logic [W-1:0] x3;
   } exp_t;

   exp_t q[$];

   logic         prev_stall = 1'b0;
   logic [W-1:0] prev_d;
   logic [W-1:0] prev_x2;
   logic [W-1:0] prev_x3;

   always #5 clk = ~clk;

   sbox_array #(.LANES(LANES)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_mode   (in_mode),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
`ifdef SBOX_XTIME_EN
      ,
      .out_x2    (out_x2),
      .out_x3    (out_x3)
`endif
   );

   task automatic check1(input string name, input logic act, input logic exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic checkw(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic build_tables();
      int ex [256];
      int lg [256];
      int v;
      int inv;
      int s;
      int bt;
      v = 1;
      for (int i = 0; i < 255; i++) begin
         ex[i] = v;
         lg[v] = i;
         v = v ^ (((v * 2) % 256) ^ ((v >= 128) ? 27 : 0));
      end
      for (int x = 0; x < 256; x++) begin
         inv = (x == 0) ? 0 : ex[(255 - lg[x]) % 255];
         s = 0;
         for (int i = 0; i < 8; i++) begin
            bt = ((inv >> i) & 1) ^ ((inv >> ((i + 4) % 8)) & 1) ^ ((inv >> ((i + 5) % 8)) & 1)
               ^ ((inv >> ((i + 6) % 8)) & 1) ^ ((inv >> ((i + 7) % 8)) & 1) ^ ((99 >> i) & 1);
            s = s | (bt << i);
         end
         sbox_t[x]  = 8'(s);
         isbox_t[s] = 8'(x);
      end
   endtask

   function automatic exp_t model(input logic [W-1:0] data, input logic mode);
      exp_t e;
      int   s;
      int   x2;
      e.d  = '0;
      e.x2 = '0;
      e.x3 = '0;
      for (int l = 0; l < LANES; l++) begin
         s  = mode ? int'(isbox_t[data[8*l +: 8]]) : int'(sbox_t[data[8*l +: 8]]);
         x2 = ((s * 2) % 256) ^ ((s >= 128) ? 27 : 0);
         e.d[8*l +: 8]  = 8'(s);
         e.x2[8*l +: 8] = 8'(x2);
         e.x3[8*l +: 8] = 8'(x2 ^ s);
      end
      return e;
   endfunction

   // Monitor: in_ready rule, stall stability, output scoreboard, input capture.
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         q.delete();
         prev_stall = 1'b0;
      end else begin
         check1("in_ready_rule", in_ready, !(q.size() == 2 && !out_ready));
         if (prev_stall) begin
            check1("stall_valid", out_valid, 1'b1);
            checkw("stall_data", out_data, prev_d);
`ifdef SBOX_XTIME_EN
            checkw("stall_x2", out_x2, prev_x2);
            checkw("stall_x3", out_x3, prev_x3);
`endif
         end
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_beat: got %h expected no beat at %0t", out_data, $time);
            end else begin
               e = q.pop_front();
               checkw("data", out_data, e.d);
`ifdef SBOX_XTIME_EN
               checkw("x2", out_x2, e.x2);
               checkw("x3", out_x3, e.x3);
`endif
            end
         end
         prev_stall = out_valid && !out_ready;
         prev_d     = out_data;
`ifdef SBOX_XTIME_EN
         prev_x2    = out_x2;
         prev_x3    = out_x3;
`endif
         if (in_valid && in_ready) begin
            q.push_back(model(in_data, in_mode));
         end
      end
   end

   // Pseudo-random downstream readiness when enabled.
   initial begin
      forever begin
         @(posedge clk);
         #2;
         if (rand_ready) begin
            out_ready = 1'($urandom_range(0, 1));
         end
      end
   end

   // Offer one beat and return one time-step after the accepting edge.
   task automatic send(input logic [W-1:0] d, input logic m);
      in_valid = 1'b1;
      in_data  = d;
      in_mode  = m;
      for (int t = 0; t < 1000; t++) begin
         @(negedge clk);
         if (in_ready) begin
            @(posedge clk);
            #1;
            return;
         end
         @(posedge clk);
         #1;
      end
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: got in_ready=0 expected acceptance at %0t", $time);
   endtask

   task automatic idle();
      in_valid = 1'b0;
      in_data  = W'($urandom);
      in_mode  = 1'($urandom_range(0, 1));
   endtask

   task automatic drain();
      for (int t = 0; t < 2000; t++) begin
         if (q.size() == 0) begin
            break;
         end
         @(posedge clk);
         #1;
      end
      if (q.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
      end
   endtask

   initial begin
      logic [W-1:0] d;
      build_tables();
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_mode   = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check1("rst_valid", out_valid, 1'b0);
      checkw("rst_data", out_data, 32'h0000_0000);
`ifdef SBOX_XTIME_EN
      checkw("rst_x2", out_x2, 32'h0000_0000);
      checkw("rst_x3", out_x3, 32'h0000_0000);
`endif
      rst = 1'b0;
      check1("rst_in_ready", in_ready, 1'b1);
      out_ready = 1'b1;

      // Directed forward beat with latency check.
      send(32'hFF53_0100, 1'b0);
      idle();
      check1("lat_early", out_valid, 1'b0);
      @(posedge clk);
      #1;
      check1("lat_valid", out_valid, 1'b1);
      checkw("fwd_directed", out_data, 32'h16ED_7C63);

      // Directed inverse beat.
      send(32'h16ED_7C63, 1'b1);
      idle();
      @(posedge clk);
      #1;
      check1("inv_valid", out_valid, 1'b1);
      checkw("inv_directed", out_data, 32'hFF53_0100);

`ifdef SBOX_XTIME_EN
      send(32'h0000_0053, 1'b0);
      idle();
      @(posedge clk);
      #1;
      checkw("xt_data", out_data, 32'h6363_63ED);
      checkw("xt_x2", out_x2, 32'hC6C6_C6C1);
      checkw("xt_x3", out_x3, 32'hA5A5_A52C);
`endif
      drain();

      // Alternating modes back-to-back.
      for (int k = 0; k < 16; k++) begin
         send(W'($urandom), 1'(k % 2));
      end
      idle();
      drain();

      // Exhaustive sweep: every byte value in every lane, both modes.
      for (int m = 0; m < 2; m++) begin
         for (int k = 0; k < 256; k++) begin
            d = '0;
            for (int l = 0; l < LANES; l++) begin
               d[8*l +: 8] = 8'((k + 37 * l) % 256);
            end
            send(d, 1'(m));
         end
      end
      idle();
      drain();

      // Eight beats under toggling backpressure.
      rand_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         send(W'($urandom), 1'($urandom_range(0, 1)));
      end
      idle();
      repeat (20) begin
         @(posedge clk);
         #1;
      end
      rand_ready = 1'b0;
      out_ready  = 1'b1;
      drain();

      // Longer random stream with input bubbles and random backpressure.
      rand_ready = 1'b1;
      for (int k = 0; k < 300; k++) begin
         if ($urandom_range(0, 3) == 0) begin
            idle();
            @(posedge clk);
            #1;
         end
         send(W'($urandom), 1'($urandom_range(0, 1)));
      end
      idle();
      rand_ready = 1'b0;
      out_ready  = 1'b1;
      drain();

      // Reset with two beats in flight: nothing stale may emerge.
      out_ready = 1'b0;
      send(W'($urandom), 1'b0);
      send(W'($urandom), 1'b1);
      idle();
      rst = 1'b1;
      @(posedge clk);
      #1;
      check1("rst_flush_valid", out_valid, 1'b0);
      rst       = 1'b0;
      out_ready = 1'b1;
      check1("rst_flush_in_ready", in_ready, 1'b1);
      repeat (6) begin
         @(posedge clk);
         #1;
      end
      check1("rst_flush_quiet", out_valid, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
